cavlc_coeff_token_ctrl: RTL and testbench
=========================================

Name: cavlc_coeff_token_ctrl

Overview:
Per-macroblock sequencer for CAVLC coeff_token encoding of the 16 luma 4x4 blocks.
- Accepts (TotalCoeff, TrailingOnes) per block in H.264 block-index order.
- Derives nC from left/top neighbour TotalCoeff and selects the VLC table (vlc0/1/2 lookup, or internal 6-bit FLC).
- Drives the shared combinational coeff_token lookup, registers the returned code, and hands it to the bit packer over valid/ready.
- Sits between the residual scan stage and the bitstream packer.

Parameters:
- BLK_NUM, 16, 4x4 blocks per macroblock.
- TC_W, 5, TotalCoeff width (0..16).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mb_start_i  in  1  start-of-MB pulse; sampled only in IDLE
- left_avail_i  in  1  left MB available; latched on mb_start_i
- top_avail_i  in  1  top MB available; latched on mb_start_i
- left_tc_i  in  20  left MB right-column TC, 4x5 bits, [4:0]=row0; latched on mb_start_i
- top_tc_i  in  20  top MB bottom-row TC, 4x5 bits, [4:0]=col0; latched on mb_start_i
- blk_valid_i  in  1  block descriptor valid
- blk_ready_o  out  1  ready for block descriptor
- total_coeff_i  in  5  TotalCoeff of block
- trailing_ones_i  in  2  TrailingOnes of block
- lut_tc_o  out  5  TotalCoeff to lookup tables
- lut_t1_o  out  2  TrailingOnes to lookup tables
- lut_sel_o  out  2  0=vlc0, 1=vlc1, 2=vlc2, 3=FLC (lookup result unused)
- lut_code_i  in  16  code from selected table (LSB-aligned)
- lut_len_i  in  5  code length from selected table
- code_valid_o  out  1  coeff_token code valid
- code_ready_i  in  1  packer accepts
- code_o  out  16  code bits, LSB-aligned
- code_len_o  out  5  code length
- blk_idx_o  out  4  index of block currently in flight
- mb_done_o  out  1  one-cycle pulse after 16th code accepted
- right_col_tc_o  out  20  this MB right-column TC (blocks 5,7,13,15); stable from mb_done_o until next mb_start_i
- bottom_row_tc_o  out  20  this MB bottom-row TC (blocks 10,11,14,15); same timing
- err_o  out  1  sticky protocol-violation flag; cleared on mb_start_i

Behaviour:
- Reset values:
  - FSM=IDLE.
  - All outputs 0.
  - TC array and latched neighbour info cleared.
- FSM states and transitions:
  - IDLE -> WAIT_BLK on mb_start_i. Clears blk_idx, latches neighbour info, clears err_o.
  - WAIT_BLK: blk_ready_o=1. On blk_valid_i&blk_ready_o, register tc/t1, compute nC, register lut_sel -> LOOKUP.
  - LOOKUP: one cycle. lut_* driven from registers; at cycle end capture lut_code_i/lut_len_i (or FLC result) into code_o/code_len_o -> EMIT.
  - EMIT: code_valid_o=1; code_o, code_len_o and code_valid_o held stable until code_ready_i. On handshake, write tc into TC array[blk_idx]. If blk_idx==15: pulse mb_done_o -> IDLE. Otherwise blk_idx++ -> WAIT_BLK.
- Latency: accept at cycle N; code_valid_o high at N+2. Minimum 3 cycles per block, 48 per MB.
- Block geometry: x={idx[2],idx[0]}, y={idx[3],idx[1]}.
  - nA = TC of (x-1,y): from current-MB array, or left_tc_i[y] when x==0.
  - nB = TC of (x,y-1): from current-MB array, or top_tc_i[x] when y==0.
  - At x==0 / y==0, availability comes from left_avail_i / top_avail_i; inside the MB always available.
- nC rules:
  - Both available: (nA+nB+1)>>1, 6-bit intermediate.
  - One available: that value.
  - Neither: 0.
- Table selection: nC 0..1 ->0; 2..3 ->1; 4..7 ->2; >=8 ->3.
- FLC (sel 3): len=6.
  - tc==0: code=6'b000011.
  - Otherwise: code={tc-1[3:0], t1}.
- Input violations (tc>16, t1>3, t1>tc): set err_o.
  - tc clamped to 16; t1 clamped to min(t1,tc,3).
  - Processing continues with clamped values.
- mb_start_i outside IDLE: ignored, err_o set.
- Reset mid-MB: immediate return to IDLE. No mb_done_o. Partial MB is lost.
- blk_valid_i outside WAIT_BLK: not accepted (blk_ready_o=0).

Decomposition:
- cavlc_pkg:
  - FSM state enum.
  - LUT_SEL_VLC0/1/2/FLC constants.
  - TC_W, FLC_LEN=6, FLC_ZERO_CODE=6'b000011.
  - Function mapping blk_idx to (x,y).
- Sub-module cavlc_nc_calc (combinational): inputs nA, nB, availA, availB; outputs nC and table select.

Test Plan:
- mb_start with no neighbours, blk0 tc=0 t1=0 -> nC=0, lut_sel_o=0; lut returns code=1/len=1 -> code_o=16'h0001, len=1, code_valid_o at N+2.
- Both neighbours available, left_tc_i[0]=3, top_tc_i[0]=4, blk0 tc=2 t1=1 -> nC=4, lut_sel_o=2.
- left_tc_i[0]=10, top unavailable, blk0 tc=5 t1=2 -> sel 3, code_o=6'b010010, len 6; repeat with tc=0 -> code_o=6'b000011.
- code_ready_i low for 5 cycles during EMIT -> code_valid_o/code_o/code_len_o held stable; blk_ready_o stays 0; accepted on cycle 6.
- Full MB, block i tc=i, no neighbours -> block3 nC=(1+2+1)>>1=2, sel 1; mb_done_o single pulse after 16th handshake; right_col_tc_o={15,13,7,5}, bottom_row_tc_o={15,14,11,10} (5-bit fields, MSB field last listed first).
- Illegal inputs:
  - tc=17 -> err_o=1, treated as 16; err_o stays set until next mb_start_i.
  - rst_n low during EMIT of blk7 -> all outputs 0 immediately; no mb_done_o.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC coeff_token sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: FSM state enum, lookup-table select codes, FLC constants,
// block-index <-> (x,y) geometry helpers for the 4x4 luma block layout.
package cavlc_pkg;

  localparam int BLK_NUM = 16;
  localparam int TC_W    = 5;

  localparam logic [1:0] LUT_SEL_VLC0 = 2'd0;
  localparam logic [1:0] LUT_SEL_VLC1 = 2'd1;
  localparam logic [1:0] LUT_SEL_VLC2 = 2'd2;
  localparam logic [1:0] LUT_SEL_FLC  = 2'd3;

  localparam logic [4:0] FLC_LEN       = 5'd6;
  localparam logic [5:0] FLC_ZERO_CODE = 6'b000011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_LOOKUP,
    S_EMIT
  } state_t;

  // Block index to {x[1:0], y[1:0]}: blocks are numbered in nested 2x2 z-order.
  function automatic logic [3:0] blk_xy(input logic [3:0] idx);
    return {idx[2], idx[0], idx[3], idx[1]};
  endfunction

  // Inverse of blk_xy.
  function automatic logic [3:0] xy_blk(input logic [1:0] x, input logic [1:0] y);
    return {y[1], x[1], y[0], x[0]};
  endfunction

endpackage

// File: rtl/cavlc_nc_calc.sv
// Combinational nC predictor and coeff_token table selector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: na/nb neighbour TotalCoeff, avail_a/avail_b neighbour availability,
//        nc predicted nC, sel table select (vlc0/vlc1/vlc2/FLC).
module cavlc_nc_calc
  import cavlc_pkg::*;
(
  input  logic [TC_W-1:0] na,
  input  logic [TC_W-1:0] nb,
  input  logic            avail_a,
  input  logic            avail_b,
  output logic [5:0]      nc,
  output logic [1:0]      sel
);

  logic [5:0] sum;

  always_comb begin
    // Max 16+16+1 = 33, fits in the 6-bit intermediate.
    sum = 6'(na) + 6'(nb) + 6'd1;
    if (avail_a && avail_b) begin
      nc = sum >> 1;
    end else if (avail_a) begin
      nc = 6'(na);
    end else if (avail_b) begin
      nc = 6'(nb);
    end else begin
      nc = 6'd0;
    end

    if (nc < 6'd2) begin
      sel = LUT_SEL_VLC0;
    end else if (nc < 6'd4) begin
      sel = LUT_SEL_VLC1;
    end else if (nc < 6'd8) begin
      sel = LUT_SEL_VLC2;
    end else begin
      sel = LUT_SEL_FLC;
    end
  end

endmodule

// File: rtl/cavlc_coeff_token_ctrl.sv
// Per-macroblock coeff_token sequencer for the 16 luma 4x4 blocks.
// Latency: block accepted at cycle N -> code_valid_o at N+2; 3 cycles/block minimum.
// Backpressure: code held in EMIT until code_ready_i; blk_ready_o low meanwhile.
// Ports: mb_start_i + neighbour info (latched at MB start); blk_valid_i/blk_ready_o
//        block descriptor in; lut_* to / lut_code_i,lut_len_i from the shared table;
//        code_valid_o/code_ready_i code out; mb_done_o, right/bottom TC out; err_o sticky.
module cavlc_coeff_token_ctrl
  import cavlc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mb_start_i,
  input  logic        left_avail_i,
  input  logic        top_avail_i,
  input  logic [19:0] left_tc_i,
  input  logic [19:0] top_tc_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  input  logic [4:0]  total_coeff_i,
  input  logic [1:0]  trailing_ones_i,
  output logic [4:0]  lut_tc_o,
  output logic [1:0]  lut_t1_o,
  output logic [1:0]  lut_sel_o,
  input  logic [15:0] lut_code_i,
  input  logic [4:0]  lut_len_i,
  output logic        code_valid_o,
  input  logic        code_ready_i,
  output logic [15:0] code_o,
  output logic [4:0]  code_len_o,
  output logic [3:0]  blk_idx_o,
  output logic        mb_done_o,
  output logic [19:0] right_col_tc_o,
  output logic [19:0] bottom_row_tc_o,
  output logic        err_o
);

  state_t          state;
  logic [TC_W-1:0] tc_arr [BLK_NUM];
  logic            left_avail_q;
  logic            top_avail_q;
  logic [19:0]     left_tc_q;
  logic [19:0]     top_tc_q;

  // Neighbour fetch for the block about to be accepted (index = blk_idx_o).
  logic [1:0]      cur_x;
  logic [1:0]      cur_y;
  logic [TC_W-1:0] na;
  logic [TC_W-1:0] nb;
  logic            avail_a;
  logic            avail_b;

  always_comb begin
    {cur_x, cur_y} = blk_xy(blk_idx_o);
    if (cur_x == 2'd0) begin
      avail_a = left_avail_q;
      na      = left_tc_q[TC_W*cur_y +: TC_W];
    end else begin
      avail_a = 1'b1;
      na      = tc_arr[xy_blk(cur_x - 2'd1, cur_y)];
    end
    if (cur_y == 2'd0) begin
      avail_b = top_avail_q;
      nb      = top_tc_q[TC_W*cur_x +: TC_W];
    end else begin
      avail_b = 1'b1;
      nb      = tc_arr[xy_blk(cur_x, cur_y - 2'd1)];
    end
  end

  // nC is kept on the calc's interface for visibility; only the select is consumed here.
  logic [5:0] nc_unused;
  logic [1:0] nc_sel;

  cavlc_nc_calc u_nc_calc (
    .na      (na),
    .nb      (nb),
    .avail_a (avail_a),
    .avail_b (avail_b),
    .nc      (nc_unused),
    .sel     (nc_sel)
  );

  // Input sanitising: out-of-range descriptors are flagged and clamped, not dropped.
  logic [TC_W-1:0] tc_clamp;
  logic [1:0]      t1_clamp;
  logic            in_err;

  always_comb begin
    tc_clamp = (total_coeff_i > 5'd16) ? 5'd16 : total_coeff_i;
    // t1 > tc_clamp implies tc_clamp <= 2, so the low two bits are exact.
    t1_clamp = ({3'd0, trailing_ones_i} > tc_clamp) ? tc_clamp[1:0] : trailing_ones_i;
    in_err   = (total_coeff_i > 5'd16) || ({3'd0, trailing_ones_i} > total_coeff_i);
  end

  // Fixed-length code used when nC >= 8.
  logic [3:0]  tc_m1;
  logic [15:0] flc_code;

  always_comb begin
    tc_m1    = 4'(lut_tc_o - 5'd1);
    flc_code = (lut_tc_o == 5'd0) ? {10'd0, FLC_ZERO_CODE} : {10'd0, tc_m1, lut_t1_o};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      blk_ready_o     <= 1'b0;
      lut_tc_o        <= '0;
      lut_t1_o        <= '0;
      lut_sel_o       <= '0;
      code_valid_o    <= 1'b0;
      code_o          <= '0;
      code_len_o      <= '0;
      blk_idx_o       <= '0;
      mb_done_o       <= 1'b0;
      right_col_tc_o  <= '0;
      bottom_row_tc_o <= '0;
      err_o           <= 1'b0;
      left_avail_q    <= 1'b0;
      top_avail_q     <= 1'b0;
      left_tc_q       <= '0;
      top_tc_q        <= '0;
      for (int i = 0; i < BLK_NUM; i++) begin
        tc_arr[i] <= '0;
      end
    end else begin
      mb_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mb_start_i) begin
            state        <= S_WAIT_BLK;
            blk_ready_o  <= 1'b1;
            blk_idx_o    <= '0;
            err_o        <= 1'b0;
            left_avail_q <= left_avail_i;
            top_avail_q  <= top_avail_i;
            left_tc_q    <= left_tc_i;
            top_tc_q     <= top_tc_i;
          end
        end
        S_WAIT_BLK: begin
          // blk_ready_o is high throughout this state.
          if (blk_valid_i) begin
            lut_tc_o    <= tc_clamp;
            lut_t1_o    <= t1_clamp;
            lut_sel_o   <= nc_sel;
            blk_ready_o <= 1'b0;
            state       <= S_LOOKUP;
            if (in_err) begin
              err_o <= 1'b1;
            end
          end
        end
        S_LOOKUP: begin
          if (lut_sel_o == LUT_SEL_FLC) begin
            code_o     <= flc_code;
            code_len_o <= FLC_LEN;
          end else begin
            code_o     <= lut_code_i;
            code_len_o <= lut_len_i;
          end
          code_valid_o <= 1'b1;
          state        <= S_EMIT;
        end
        S_EMIT: begin
          if (code_ready_i) begin
            code_valid_o      <= 1'b0;
            tc_arr[blk_idx_o] <= lut_tc_o;
            if (blk_idx_o == 4'd15) begin
              // Block 15 is in flight, so its TC comes from lut_tc_o, not the array.
              right_col_tc_o  <= {lut_tc_o, tc_arr[13], tc_arr[7], tc_arr[5]};
              bottom_row_tc_o <= {lut_tc_o, tc_arr[14], tc_arr[11], tc_arr[10]};
              mb_done_o       <= 1'b1;
              state           <= S_IDLE;
            end else begin
              blk_idx_o   <= blk_idx_o + 4'd1;
              blk_ready_o <= 1'b1;
              state       <= S_WAIT_BLK;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (mb_start_i && (state != S_IDLE)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cavlc_coeff_token_ctrl.sv
module tb_cavlc_coeff_token_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mb_start_i = 1'b0;
  logic        left_avail_i = 1'b0;
  logic        top_avail_i = 1'b0;
  logic [19:0] left_tc_i = '0;
  logic [19:0] top_tc_i = '0;
  logic        blk_valid_i = 1'b0;
  logic        blk_ready_o;
  logic [4:0]  total_coeff_i = '0;
  logic [1:0]  trailing_ones_i = '0;
  logic [4:0]  lut_tc_o;
  logic [1:0]  lut_t1_o;
  logic [1:0]  lut_sel_o;
  logic [15:0] lut_code_i;
  logic [4:0]  lut_len_i;
  logic        code_valid_o;
  logic        code_ready_i = 1'b0;
  logic [15:0] code_o;
  logic [4:0]  code_len_o;
  logic [3:0]  blk_idx_o;
  logic        mb_done_o;
  logic [19:0] right_col_tc_o;
  logic [19:0] bottom_row_tc_o;
  logic        err_o;

  always #5 clk = ~clk;

  cavlc_coeff_token_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mb_start_i      (mb_start_i),
    .left_avail_i    (left_avail_i),
    .top_avail_i     (top_avail_i),
    .left_tc_i       (left_tc_i),
    .top_tc_i        (top_tc_i),
    .blk_valid_i     (blk_valid_i),
    .blk_ready_o     (blk_ready_o),
    .total_coeff_i   (total_coeff_i),
    .trailing_ones_i (trailing_ones_i),
    .lut_tc_o        (lut_tc_o),
    .lut_t1_o        (lut_t1_o),
    .lut_sel_o       (lut_sel_o),
    .lut_code_i      (lut_code_i),
    .lut_len_i       (lut_len_i),
    .code_valid_o    (code_valid_o),
    .code_ready_i    (code_ready_i),
    .code_o          (code_o),
    .code_len_o      (code_len_o),
    .blk_idx_o       (blk_idx_o),
    .mb_done_o       (mb_done_o),
    .right_col_tc_o  (right_col_tc_o),
    .bottom_row_tc_o (bottom_row_tc_o),
    .err_o           (err_o)
  );

  // Stand-in for the shared coeff_token tables: {len, code}. The (0,0) entry returns 1/len1 on vlc0.
  function automatic logic [20:0] lut_fn(input logic [1:0] sel, input logic [4:0] tc, input logic [1:0] t1);
    int l;
    if (tc == 5'd0 && t1 == 2'd0) begin
      return {5'(1 + int'(sel)), 16'h0001};
    end
    l = int'(tc) + int'(t1) + int'(sel) + 2;
    return {5'(l), 16'hA000 ^ {7'd0, sel, t1, tc}};
  endfunction

  always_comb {lut_len_i, lut_code_i} = lut_fn(lut_sel_o, lut_tc_o, lut_t1_o);

  logic [77:0] all_out;
  assign all_out = {blk_ready_o, lut_tc_o, lut_t1_o, lut_sel_o, code_valid_o, code_o, code_len_o,
                    blk_idx_o, mb_done_o, right_col_tc_o, bottom_row_tc_o, err_o};

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_left_avail, m_top_avail;
  int m_left_tc[4];
  int m_top_tc[4];
  int m_arr[16];
  int m_idx;
  bit m_err;

  function automatic int bx(input int i);
    return ((i >> 2) & 1) * 2 + (i & 1);
  endfunction

  function automatic int by(input int i);
    return ((i >> 3) & 1) * 2 + ((i >> 1) & 1);
  endfunction

  function automatic int blk_at(input int x, input int y);
    for (int i = 0; i < 16; i++) if (bx(i) == x && by(i) == y) return i;
    return 0;
  endfunction

  task automatic model_clear();
    m_left_avail = 0; m_top_avail = 0; m_idx = 0; m_err = 0;
    for (int i = 0; i < 4; i++) begin m_left_tc[i] = 0; m_top_tc[i] = 0; end
    for (int i = 0; i < 16; i++) m_arr[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mb_start_i = 0; blk_valid_i = 0; code_ready_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic start_mb(input bit la, input bit ta, input logic [19:0] ltc, input logic [19:0] ttc);
    left_avail_i = la; top_avail_i = ta; left_tc_i = ltc; top_tc_i = ttc;
    mb_start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mb_start_i = 1'b0;
    m_left_avail = la; m_top_avail = ta; m_idx = 0; m_err = 0;
    for (int r = 0; r < 4; r++) begin
      m_left_tc[r] = int'(ltc[5*r +: 5]);
      m_top_tc[r]  = int'(ttc[5*r +: 5]);
    end
    checks++;
    if (blk_ready_o !== 1'b1 || err_o !== 1'b0 || blk_idx_o !== 4'd0) begin
      errors++;
      $display("FAIL mb_start: ready/err/idx got %b/%b/%0d want 1/0/0", blk_ready_o, err_o, blk_idx_o);
    end
  endtask

  // Sends one block and checks the full path against the model. Leaves at a negedge.
  task automatic send_block(input int tc, input int t1, input int hold,
                            output int obs_sel, output int obs_code, output int obs_len);
    int x, y, na, nb, nc, sel, ctc, ct1, ecode, elen, waited;
    bit aa, ab, e;
    logic [20:0] lr;
    obs_sel = -1; obs_code = -1; obs_len = -1;
    x = bx(m_idx); y = by(m_idx);
    if (x == 0) begin aa = m_left_avail; na = m_left_tc[y]; end
    else begin aa = 1; na = m_arr[blk_at(x - 1, y)]; end
    if (y == 0) begin ab = m_top_avail; nb = m_top_tc[x]; end
    else begin ab = 1; nb = m_arr[blk_at(x, y - 1)]; end
    if (aa && ab) nc = (na + nb + 1) / 2;
    else if (aa) nc = na;
    else if (ab) nc = nb;
    else nc = 0;
    sel = (nc < 2) ? 0 : (nc < 4) ? 1 : (nc < 8) ? 2 : 3;
    ctc = (tc > 16) ? 16 : tc;
    ct1 = (t1 > ctc) ? ctc : t1;
    e = (tc > 16) || (t1 > tc);
    if (sel == 3) begin
      elen = 6;
      ecode = (ctc == 0) ? 3 : (((ctc - 1) & 15) * 4 + ct1);
    end else begin
      lr = lut_fn(2'(sel), 5'(ctc), 2'(ct1));
      elen = int'(lr[20:16]); ecode = int'(lr[15:0]);
    end
    m_err = m_err | e;

    waited = 0;
    while (blk_ready_o !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    if (blk_ready_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL blk_ready_timeout blk%0d: got %b want 1", m_idx, blk_ready_o);
      return;
    end
    blk_valid_i = 1'b1; total_coeff_i = 5'(tc); trailing_ones_i = 2'(t1);
    @(posedge clk);
    @(negedge clk);
    blk_valid_i = 1'b0;
    // N+1: lookup cycle
    obs_sel = int'(lut_sel_o);
    checks++;
    if (lut_sel_o !== 2'(sel) || lut_tc_o !== 5'(ctc) || lut_t1_o !== 2'(ct1)) begin
      errors++;
      $display("FAIL lut_drive blk%0d: sel/tc/t1 got %0d/%0d/%0d want %0d/%0d/%0d",
               m_idx, lut_sel_o, lut_tc_o, lut_t1_o, sel, ctc, ct1);
    end
    checks++;
    if (code_valid_o !== 1'b0 || blk_ready_o !== 1'b0 || err_o !== m_err) begin
      errors++;
      $display("FAIL lookup_cycle blk%0d: valid/ready/err got %b/%b/%b want 0/0/%b",
               m_idx, code_valid_o, blk_ready_o, err_o, m_err);
    end
    @(negedge clk);
    // N+2: code must be presented
    obs_code = int'(code_o); obs_len = int'(code_len_o);
    checks++;
    if (code_valid_o !== 1'b1 || code_o !== 16'(ecode) || code_len_o !== 5'(elen) || blk_idx_o !== 4'(m_idx)) begin
      errors++;
      $display("FAIL emit blk%0d: valid/code/len/idx got %b/%h/%0d/%0d want 1/%h/%0d/%0d",
               m_idx, code_valid_o, code_o, code_len_o, blk_idx_o, 16'(ecode), elen, m_idx);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (code_valid_o !== 1'b1 || code_o !== 16'(ecode) || code_len_o !== 5'(elen) || blk_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL hold blk%0d cyc%0d: valid/code/len/ready got %b/%h/%0d/%b want 1/%h/%0d/0",
                 m_idx, h, code_valid_o, code_o, code_len_o, blk_ready_o, 16'(ecode), elen);
      end
    end
    code_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    code_ready_i = 1'b0;
    checks++;
    if (code_valid_o !== 1'b0 || mb_done_o !== (m_idx == 15)) begin
      errors++;
      $display("FAIL handshake blk%0d: valid/mb_done got %b/%b want 0/%b", m_idx, code_valid_o, mb_done_o, m_idx == 15);
    end
    m_arr[m_idx] = ctc;
    if (m_idx == 15) begin
      @(negedge clk);
      checks++;
      if (mb_done_o !== 1'b0 || blk_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL mb_done_pulse: mb_done/ready got %b/%b want 0/0", mb_done_o, blk_ready_o);
      end
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL idle_outputs: got %h want 0", all_out); end
  endtask

  task automatic test_basic();
    int s, c, l;
    do_reset();
    start_mb(0, 0, 20'd0, 20'd0);
    send_block(0, 0, 0, s, c, l);
    checks++;
    if (s != 0 || c != 1 || l != 1) begin
      errors++; $display("FAIL basic_blk0: sel/code/len got %0d/%0d/%0d want 0/1/1", s, c, l);
    end
  endtask

  task automatic test_nc_both();
    int s, c, l;
    do_reset();
    start_mb(1, 1, 20'd3, 20'd4);
    send_block(2, 1, 0, s, c, l);
    checks++;
    if (s != 2) begin errors++; $display("FAIL nc_both_sel: got %0d want 2", s); end
  endtask

  task automatic test_flc();
    int s, c, l;
    do_reset();
    start_mb(1, 0, 20'd10, 20'd0);
    send_block(5, 2, 0, s, c, l);
    checks++;
    if (s != 3 || c != 18 || l != 6) begin
      errors++; $display("FAIL flc_tc5: sel/code/len got %0d/%0d/%0d want 3/18/6", s, c, l);
    end
    do_reset();
    start_mb(1, 0, 20'd10, 20'd0);
    send_block(0, 0, 0, s, c, l);
    checks++;
    if (s != 3 || c != 3 || l != 6) begin
      errors++; $display("FAIL flc_tc0: sel/code/len got %0d/%0d/%0d want 3/3/6", s, c, l);
    end
  endtask

  task automatic test_backpressure();
    int s, c, l;
    do_reset();
    start_mb(1, 1, 20'h18c63, 20'h08421);
    send_block(7, 3, 5, s, c, l);
    send_block(1, 1, 2, s, c, l);
  endtask

  task automatic test_full_mb();
    int s, c, l;
    do_reset();
    start_mb(0, 0, 20'd0, 20'd0);
    for (int i = 0; i < 16; i++) begin
      send_block(i, i % 4, 0, s, c, l);
      if (i == 3) begin
        checks++;
        if (s != 1) begin errors++; $display("FAIL full_blk3_sel: got %0d want 1", s); end
      end
    end
    checks++;
    if (right_col_tc_o !== {5'd15, 5'd13, 5'd7, 5'd5} || bottom_row_tc_o !== {5'd15, 5'd14, 5'd11, 5'd10}) begin
      errors++;
      $display("FAIL full_edges: right/bottom got %h/%h want %h/%h", right_col_tc_o, bottom_row_tc_o,
               {5'd15, 5'd13, 5'd7, 5'd5}, {5'd15, 5'd14, 5'd11, 5'd10});
    end
  endtask

  task automatic test_illegal();
    int s, c, l;
    do_reset();
    start_mb(0, 0, 20'd0, 20'd0);
    send_block(17, 0, 0, s, c, l);
    send_block(1, 3, 0, s, c, l);
    // mb_start while busy: ignored but flagged
    mb_start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mb_start_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || blk_idx_o !== 4'd2 || blk_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_mb_start: err/idx/ready got %b/%0d/%b want 1/2/1", err_o, blk_idx_o, blk_ready_o);
    end
    for (int i = 2; i < 16; i++) send_block(int'($urandom_range(0, 16)), 0, 0, s, c, l);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
    start_mb(0, 0, 20'd0, 20'd0);
  endtask

  task automatic test_reset_mid();
    int s, c, l;
    do_reset();
    start_mb(1, 1, 20'h2108f, 20'h10c41);
    for (int i = 0; i < 7; i++) send_block(int'($urandom_range(0, 16)), int'($urandom_range(0, 3)), 0, s, c, l);
    blk_valid_i = 1'b1; total_coeff_i = 5'd3; trailing_ones_i = 2'd1;
    @(posedge clk);
    @(negedge clk);
    blk_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (code_valid_o !== 1'b1 || blk_idx_o !== 4'd7) begin
      errors++; $display("FAIL mid_emit: valid/idx got %b/%0d want 1/7", code_valid_o, blk_idx_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", all_out); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mb_done_o !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b want 0", mb_done_o); end
    end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_random_mbs();
    int s, c, l, tc;
    logic [19:0] ltc, ttc;
    bit exp_right_ok;
    for (int mb = 0; mb < 4; mb++) begin
      for (int r = 0; r < 4; r++) begin
        ltc[5*r +: 5] = 5'($urandom_range(0, 16));
        ttc[5*r +: 5] = 5'($urandom_range(0, 16));
      end
      start_mb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ltc, ttc);
      for (int i = 0; i < 16; i++) begin
        tc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
        send_block(tc, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), s, c, l);
      end
      exp_right_ok = (right_col_tc_o === {5'(m_arr[15]), 5'(m_arr[13]), 5'(m_arr[7]), 5'(m_arr[5])}) &&
                     (bottom_row_tc_o === {5'(m_arr[15]), 5'(m_arr[14]), 5'(m_arr[11]), 5'(m_arr[10])});
      checks++;
      if (!exp_right_ok || err_o !== m_err) begin
        errors++;
        $display("FAIL random_mb%0d: right/bottom/err got %h/%h/%b want match model err %b",
                 mb, right_col_tc_o, bottom_row_tc_o, err_o, m_err);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_nc_both();
    test_flc();
    test_backpressure();
    test_full_mb();
    test_illegal();
    test_reset_mid();
    test_random_mbs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
